// File: rtl/shift_normalizer_pkg.sv
// rtl/shift_normalizer_pkg.sv - shared state enum, width default and dir encoding for the normalizer
package shift_norm_pkg;

   // Controller states: waiting for a word, walking it, holding the result
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } norm_state_e;

   localparam int NORM_WIDTH_DEFAULT = 8;

   // Same encoding the barrel shifter uses, so a result can be fed straight back
   localparam logic DIR_LEFT  = 1'b0;
   localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/shift_normalizer_if.sv
// rtl/shift_normalizer_if.sv - request/result handshake bundle for shift_normalizer
interface shift_normalizer_if
   import shift_norm_pkg::*;
#(
   parameter int WIDTH = NORM_WIDTH_DEFAULT
);
   localparam int SHW = $clog2(WIDTH);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] IN;
   logic             dir;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] OUT;
   logic [SHW-1:0]   shift;
   logic             zero;

   // Requester / result consumer side
   modport master (
      output in_valid, IN, dir, out_ready,
      input  in_ready, out_valid, OUT, shift, zero
   );

   // Normalizer side
   modport slave (
      input  in_valid, IN, dir, out_ready,
      output in_ready, out_valid, OUT, shift, zero
   );

endinterface

// File: rtl/shift_normalizer.sv
// rtl/shift_normalizer.sv - iterative one-bit-per-cycle normalizer; macro SHIFT_NORMALIZER_ZERO_SKIP_EN enables early exit on an all-zero word
module shift_normalizer
   import shift_norm_pkg::*;
#(
   parameter int WIDTH = NORM_WIDTH_DEFAULT
) (
   input  logic               clk,
   input  logic               rst,
   shift_normalizer_if.slave  bus
);
   localparam int SHW = $clog2(WIDTH);

   norm_state_e      state_q, state_d;
   logic [WIDTH-1:0] work_q,  work_d;
   logic [SHW-1:0]   cnt_q,   cnt_d;
   logic             dir_q,   dir_d;
   logic [WIDTH-1:0] out_q,   out_d;
   logic [SHW-1:0]   shift_q, shift_d;
   logic             zero_q,  zero_d;

   logic target_bit;
   logic give_up;

   assign target_bit = (dir_q == DIR_RIGHT) ? work_q[0] : work_q[WIDTH-1];

   // A zero word never reaches the target bit; either stop as soon as it is seen
   // or walk the full distance so latency does not depend on the data
`ifdef SHIFT_NORMALIZER_ZERO_SKIP_EN
   assign give_up = (work_q == '0);
`else
   assign give_up = (cnt_q == SHW'(WIDTH-1));
`endif

   // State and datapath registers; reset aborts any operation in flight
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         work_q  <= '0;
         cnt_q   <= '0;
         dir_q   <= DIR_LEFT;
         out_q   <= '0;
         shift_q <= '0;
         zero_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         work_q  <= work_d;
         cnt_q   <= cnt_d;
         dir_q   <= dir_d;
         out_q   <= out_d;
         shift_q <= shift_d;
         zero_q  <= zero_d;
      end
   end

   // Next state and datapath; results are only written on entry to DONE
   always_comb begin
      state_d = state_q;
      work_d  = work_q;
      cnt_d   = cnt_q;
      dir_d   = dir_q;
      out_d   = out_q;
      shift_d = shift_q;
      zero_d  = zero_q;
      unique case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               work_d  = bus.IN;
               cnt_d   = '0;
               dir_d   = bus.dir;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (target_bit) begin
               out_d   = work_q;
               shift_d = cnt_q;
               zero_d  = 1'b0;
               state_d = DONE;
            end else if (give_up) begin
               out_d   = '0;
               shift_d = '0;
               zero_d  = 1'b1;
               state_d = DONE;
            end else begin
               work_d = (dir_q == DIR_RIGHT) ? (work_q >> 1) : (work_q << 1);
               cnt_d  = cnt_q + SHW'(1);
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.OUT       = out_q;
   assign bus.shift     = shift_q;
   assign bus.zero      = zero_q;

endmodule

// File: tb/tb_shift_normalizer.sv
// tb/tb_shift_normalizer.sv - directed and round-trip checks of shift_normalizer
module tb_shift_normalizer;
   import shift_norm_pkg::*;

   localparam int W = 8;

`ifdef SHIFT_NORMALIZER_ZERO_SKIP_EN
   localparam int ZERO_LAT = 2;
`else
   localparam int ZERO_LAT = W + 1;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   vectors = 0;
   int   miscompares = 0;

   shift_normalizer_if #(.WIDTH(W)) bus ();

   shift_normalizer #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one request, measure latency (accepting edge counts as 1), check the
   // result, hold it under backpressure for hold cycles, then release
   task automatic run(input logic [7:0] din, input logic d, input logic [7:0] exp_out,
                      input logic [2:0] exp_sh, input logic exp_z, input int exp_lat,
                      input int hold);
      int lat;
      check("in_ready_idle", bus.in_ready, 1);
      bus.in_valid = 1'b1;
      bus.IN       = din;
      bus.dir      = d;
      tick();
      bus.in_valid = 1'b0;
      bus.IN       = 8'($urandom);
      bus.dir      = 1'($urandom);
      lat = 1;
      do begin
         tick();
         lat++;
      end while (!bus.out_valid && lat < 40);
      check("out_valid", bus.out_valid, 1);
      check("latency", lat, exp_lat);
      check("OUT", bus.OUT, exp_out);
      check("shift", bus.shift, exp_sh);
      check("zero", bus.zero, exp_z);
      for (int i = 0; i < hold; i++) begin
         bus.in_valid = 1'b1;
         bus.IN       = 8'h01;
         bus.dir      = DIR_LEFT;
         tick();
         bus.in_valid = 1'b0;
         check("bp_out_valid", bus.out_valid, 1);
         check("bp_in_ready", bus.in_ready, 0);
         check("bp_OUT", bus.OUT, exp_out);
         check("bp_shift", bus.shift, exp_sh);
         check("bp_zero", bus.zero, exp_z);
      end
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      check("rel_in_ready", bus.in_ready, 1);
      check("rel_out_valid", bus.out_valid, 0);
      check("hold_OUT", bus.OUT, exp_out);
   endtask

   initial begin
      logic [7:0] din, eo, back;
      logic       d, seen;
      int         cz;

      bus.in_valid  = 1'b0;
      bus.IN        = '0;
      bus.dir       = DIR_LEFT;
      bus.out_ready = 1'b0;
      repeat (2) tick();
      rst = 1'b0;
      tick();

      check("rst_in_ready", bus.in_ready, 1);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_OUT", bus.OUT, 0);
      check("rst_shift", bus.shift, 0);
      check("rst_zero", bus.zero, 0);

      run(8'h10, DIR_LEFT,  8'h80, 3'd3, 1'b0, 5, 0);
      run(8'h0C, DIR_RIGHT, 8'h03, 3'd2, 1'b0, 4, 0);
      run(8'h80, DIR_LEFT,  8'h80, 3'd0, 1'b0, 2, 0);
      run(8'h01, DIR_LEFT,  8'h80, 3'd7, 1'b0, 9, 0);
      run(8'h80, DIR_RIGHT, 8'h01, 3'd7, 1'b0, 9, 0);
      run(8'h00, DIR_LEFT,  8'h00, 3'd0, 1'b1, ZERO_LAT, 0);
      run(8'h00, DIR_RIGHT, 8'h00, 3'd0, 1'b1, ZERO_LAT, 0);
      run(8'h10, DIR_LEFT,  8'h80, 3'd3, 1'b0, 5, 5);

      // Abort mid-walk with reset
      bus.in_valid = 1'b1;
      bus.IN       = 8'h02;
      bus.dir      = DIR_LEFT;
      tick();
      bus.in_valid = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      #1;
      check("abort_in_ready", bus.in_ready, 1);
      check("abort_out_valid", bus.out_valid, 0);
      check("abort_OUT", bus.OUT, 0);
      check("abort_shift", bus.shift, 0);
      check("abort_zero", bus.zero, 0);
      tick();
      rst = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (bus.out_valid) seen = 1'b1;
      end
      check("abort_no_valid", seen, 0);
      run(8'h40, DIR_LEFT, 8'h80, 3'd1, 1'b0, 3, 0);

      // Round trip against a zero-count model and the opposite-direction barrel shift
      for (int n = 0; n < 1000; n++) begin
         din = 8'($urandom_range(1, 255));
         d   = 1'($urandom);
         cz  = 0;
         if (d == DIR_LEFT) begin
            for (int b = 7; b >= 0 && !din[b]; b--) cz++;
            eo = din << cz;
         end else begin
            for (int b = 0; b < 8 && !din[b]; b++) cz++;
            eo = din >> cz;
         end
         run(din, d, eo, 3'(cz), 1'b0, cz + 2, 0);
         back = (d == DIR_LEFT) ? (bus.OUT >> bus.shift) : (bus.OUT << bus.shift);
         check("round_trip", back, din);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/shift_normalizer.md
# shift_normalizer

Iterative 8-bit normalizer, the inverse of the datapath's barrel shift. Takes a word and shifts it one bit per cycle toward the MSB (left) or LSB (right) until the target end bit is set. Reports the normalized word, the shift distance, and a zero flag. Feeding OUT and shift back through the barrel shifter in the opposite direction reproduces IN exactly. Valid/ready handshakes on both sides.

## Interface
- WIDTH, 8: data width. Must be a power of two, ≥ 2.
- SHW, $clog2(WIDTH): width of shift. Derived localparam, not overridable.
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  request present
- in_ready  output  1  block idle, can accept
- IN  input  WIDTH  word to normalize
- dir  input  1  1 = normalize right (toward LSB), 0 = normalize left (toward MSB); sampled with IN
- out_valid  output  1  result available
- out_ready  input  1  consumer takes result
- OUT  output  WIDTH  normalized word
- shift  output  SHW  bit positions shifted
- zero  output  1  input word was all zeros

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE
  - in_ready = 1 (combinational from state).
  - On in_valid & in_ready: load work register ← IN, cnt ← 0, latch dir; go to SHIFT.
- SHIFT
  - Target bit is work[WIDTH-1] for dir=0 and work[0] for dir=1.
  - If the target bit is set: go to DONE; OUT ← work, shift ← cnt, zero ← 0.
  - Else if the terminate-on-zero condition holds (see Configuration): go to DONE; OUT ← 0, shift ← 0, zero ← 1.
  - Otherwise: work ← work shifted 1 toward the target (zero fill), cnt ← cnt + 1.
- DONE
  - out_valid = 1.
  - On out_ready: go to IDLE.
  - No same-cycle acceptance of a new request. in_ready rises the cycle after the DONE exit.
- OUT, shift and zero are updated only on DONE entry. They hold their value at all other times, including across IDLE.
- For a nonzero input the result always satisfies: barrel shift of OUT by shift, opposite direction = IN.
- cnt never exceeds WIDTH-1 and does not wrap.

## Timing
- Reset values: state IDLE, in_ready 1, out_valid 0, OUT 0, shift 0, zero 0, internal work and cnt 0.
- Nonzero input needing k shifts: out_valid rises k+2 clock edges after the accepting edge.
  - k = 0 gives 2; k = WIDTH-1 gives WIDTH+1.
- Zero input: 2 edges with ZERO_SKIP compiled in, WIDTH+1 edges without.
- Throughput: one request per k+3 cycles minimum with out_ready held high.
- While out_valid = 1, OUT/shift/zero are stable until the out_ready handshake. in_valid is ignored outside IDLE.
- Reset asserted in any state aborts the operation immediately. No output handshake occurs for the aborted request.
- dir and IN are don't-care except on the accepting edge.

## Configuration
- Macro: SHIFT_NORMALIZER_ZERO_SKIP_EN.
- Defined: the SHIFT terminate-on-zero condition is work == 0. A zero input completes in 2 cycles, same as k = 0.
- Undefined: the condition is cnt == WIDTH-1. A zero input walks the full WIDTH-1 shifts before reporting zero = 1, giving fixed worst-case latency for timing-budgeted users.
- OUT/shift/zero values are identical either way. Only latency differs.

## Structure
- Shared package shift_norm_pkg holds:
  - the state enum (IDLE, SHIFT, DONE);
  - NORM_WIDTH_DEFAULT = 8;
  - the dir encoding constants DIR_LEFT = 0 and DIR_RIGHT = 1, shared with the barrel shifter.
- No sub-module. FSM and one-bit shifting datapath stay in a single module.

## Test plan
- Left shift: dir=0, IN=0x10 → OUT=0x80, shift=3, zero=0, out_valid 5 edges after accept.
- Right shift: dir=1, IN=0x0C → OUT=0x03, shift=2, zero=0, latency 4.
- Edge cases:
  - dir=0, IN=0x80 → shift=0, latency 2.
  - IN=0x01, dir=0 → OUT=0x80, shift=7, latency 9.
  - IN=0x00 → OUT=0, shift=0, zero=1, latency 2 with the macro and 9 without.
- Backpressure: out_ready held low 5 cycles in DONE → OUT/shift/zero stable, in_ready=0, pulsed in_valid ignored. Release → IDLE next cycle.
- Reset during SHIFT (IN=0x02, dir=0, reset after 3 cycles) → all outputs at reset values with no out_valid pulse. A following IN=0x40 request → OUT=0x80, shift=1.
- Random round trip, 1000 nonzero vectors with random dir:
  - pass OUT and shift through the barrel shifter with the opposite dir and compare to IN;
  - check that shift equals the leading/trailing zero count of IN.
